hazard_scoreboard: RTL and testbench

- Tracks destination registers of instructions in flight between decode and write-back.
- Raises a stall request to the decode stage and fetch when a decoded source operand depends on a write that is still pending.
- Sits beside the decode stage. It consumes decode's src/dst/control outputs and the global freeze/flush signals, and drives the decode freeze input plus the PC/IF-ID hold.
- Also exports a pending-register mask and a saturating stall counter for debug/performance.

---
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_scoreboard.sv | 71 +++++++
 tb/tb_hazard_scoreboard.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side bundle between decode stage and hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 freeze;
    logic                 flush;
    logic [3:0]           src1;
    logic [3:0]           src2;
    logic                 has_src1;
    logic                 has_src2;
    logic [3:0]           id_dst;
    logic                 id_wb_en;
    logic                 id_mem_read;
    logic                 hazard;
    logic [15:0]          pending_mask;
    logic [CNT_WIDTH-1:0] stall_count;

    // decode / pipeline control side
    modport master (
        output freeze, flush, src1, src2, has_src1, has_src2,
               id_dst, id_wb_en, id_mem_read,
        input  hazard, pending_mask, stall_count
    );

    // scoreboard side
    modport slave (
        input  freeze, flush, src1, src2, has_src1, has_src2,
               id_dst, id_wb_en, id_mem_read,
        output hazard, pending_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard beside decode; optional FORWARDING_EN limits stalls to load-use
module hazard_scoreboard #(
    parameter int TRACK_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // entry 0 is the instruction in EX, entry k is k stages further down
    logic [TRACK_DEPTH-1:0] r_valid;
    logic [TRACK_DEPTH-1:0] r_load;
    logic [3:0]             r_dst [TRACK_DEPTH];
    logic [CNT_WIDTH-1:0]   r_stall_count;

    logic [TRACK_DEPTH-1:0] w_match;
    logic                   w_hazard;
    logic [15:0]            w_pending_mask;

    // per-entry source match, pending mask and stall decision
    always_comb begin
        w_match        = '0;
        w_pending_mask = '0;
        for (int k = 0; k < TRACK_DEPTH; k++) begin
            w_match[k] = r_valid[k] &
                         ((bus.has_src1 & (r_dst[k] == bus.src1)) |
                          (bus.has_src2 & (r_dst[k] == bus.src2)));
            if (r_valid[k]) begin
                w_pending_mask[r_dst[k]] = 1'b1;
            end
        end
`ifdef FORWARDING_EN
        // only a load in EX cannot be forwarded in time
        w_hazard = w_match[0] & r_load[0];
`else
        w_hazard = |w_match;
`endif
    end

    // shift the tracked writes one stage per advancing cycle; bubble on stall or flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid       <= '0;
            r_load        <= '0;
            r_stall_count <= '0;
            for (int k = 0; k < TRACK_DEPTH; k++) begin
                r_dst[k] <= 4'd0;
            end
        end else if (!bus.freeze) begin
            for (int k = 1; k < TRACK_DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_load[k]  <= r_load[k-1];
                r_dst[k]   <= r_dst[k-1];
            end
            r_valid[0] <= bus.id_wb_en & ~w_hazard & ~bus.flush;
            r_load[0]  <= bus.id_mem_read;
            r_dst[0]   <= bus.id_dst;
            // a flushed instruction is not a stall even if it also had a hazard
            if (w_hazard && !bus.flush && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end
        end
    end

    assign bus.hazard       = w_hazard;
    assign bus.pending_mask = w_pending_mask;
    assign bus.stall_count  = r_stall_count;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int TD    = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    hazard_scoreboard_if #(.CNT_WIDTH(CNT_W)) bus ();

    hazard_scoreboard #(.TRACK_DEPTH(TD), .CNT_WIDTH(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: list of issued writes stamped with the advance count at issue
    typedef struct {
        int dst;
        bit ld;
        int adv;
    } rec_t;

    rec_t recs[$];
    int   adv_cnt;
    int   m_cnt;

    bit             exp_haz[$];
    logic [15:0]    exp_mask[$];
    int             exp_cnt[$];

    int n_cmp;
    int n_fail;

    function automatic bit model_hazard(input bit h1, input bit h2, input int s1, input int s2);
        bit hz;
        hz = 1'b0;
        foreach (recs[i]) begin
            int age;
            bit m;
            age = adv_cnt - recs[i].adv;
            m   = (h1 && recs[i].dst == s1) || (h2 && recs[i].dst == s2);
`ifdef FORWARDING_EN
            if (m && age == 0 && recs[i].ld) hz = 1'b1;
`else
            if (m && age < TD) hz = 1'b1;
`endif
        end
        return hz;
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] mk;
        mk = '0;
        foreach (recs[i]) begin
            if (adv_cnt - recs[i].adv < TD) mk[recs[i].dst] = 1'b1;
        end
        return mk;
    endfunction

    task automatic step(input bit r, input bit fr, input bit fl,
                        input int s1, input int s2, input bit h1, input bit h2,
                        input int d, input bit wb, input bit ld);
        bit hz;
        rst             = r;
        bus.freeze      = fr;
        bus.flush       = fl;
        bus.src1        = 4'(s1);
        bus.src2        = 4'(s2);
        bus.has_src1    = h1;
        bus.has_src2    = h2;
        bus.id_dst      = 4'(d);
        bus.id_wb_en    = wb;
        bus.id_mem_read = ld;
        hz = model_hazard(h1, h2, s1, s2);
        exp_haz.push_back(hz);
        exp_mask.push_back(model_mask());
        exp_cnt.push_back(m_cnt);
        @(posedge clk);
        if (!r) begin
            recs.delete();
            m_cnt = 0;
        end else if (!fr) begin
            if (hz && !fl && m_cnt < CMAX) m_cnt++;
            adv_cnt++;
            if (wb && !hz && !fl) recs.push_back('{d, ld, adv_cnt});
            while (recs.size() > 0 && adv_cnt - recs[0].adv >= TD) void'(recs.pop_front());
        end
        #1;
    endtask

    // monitor: compare DUT outputs against the oldest pending expectation
    always @(negedge clk) begin
        if (exp_haz.size() > 0) begin
            bit          eh;
            logic [15:0] em;
            int          ec;
            eh = exp_haz.pop_front();
            em = exp_mask.pop_front();
            ec = exp_cnt.pop_front();
            n_cmp++;
            if (bus.hazard !== eh) begin
                n_fail++;
                $display("FAIL hazard t=%0t got %b expected %b", $time, bus.hazard, eh);
            end
            n_cmp++;
            if (bus.pending_mask !== em) begin
                n_fail++;
                $display("FAIL pending_mask t=%0t got %h expected %h", $time, bus.pending_mask, em);
            end
            n_cmp++;
            if (bus.stall_count !== CNT_W'(ec)) begin
                n_fail++;
                $display("FAIL stall_count t=%0t got %0d expected %0d", $time, bus.stall_count, ec);
            end
        end
    end

    function automatic int rreg();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        n_cmp = 0; n_fail = 0; adv_cnt = 0; m_cnt = 0;
        rst = 1'b0;
        bus.freeze = 0; bus.flush = 0; bus.src1 = 0; bus.src2 = 0;
        bus.has_src1 = 0; bus.has_src2 = 0; bus.id_dst = 0;
        bus.id_wb_en = 0; bus.id_mem_read = 0;
        @(posedge clk);
        #1;
        // reset with arbitrary inputs
        step(0, 0, 0, 3, 3, 1, 1, 3, 1, 0);
        step(0, 1, 0, 5, 7, 1, 1, 9, 1, 1);
        // simple issue, then RAW on a non-load
        step(1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
        // load-use on src2
        step(1, 0, 0, 0, 0, 0, 0, 2, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 2, 0, 1, 0, 0, 0);
        // freeze holding a pending dst=7 (load so both builds stall)
        step(1, 0, 0, 0, 0, 0, 0, 7, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 7, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 7, 0, 1, 0, 0, 0, 0);
        // flush kills the decode write; flush over a hazard is not counted
        step(1, 0, 1, 0, 0, 0, 0, 9, 1, 0);
        step(1, 0, 0, 9, 9, 1, 1, 15, 1, 1);
        step(1, 0, 1, 15, 15, 1, 1, 4, 1, 0);
        // has_src1 masks a real match; register 15 behaves normally
        step(1, 0, 0, 0, 0, 0, 0, 15, 1, 1);
        step(1, 0, 0, 15, 15, 0, 0, 1, 0, 0);
        step(1, 0, 0, 15, 15, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-stall discards the entries
        step(1, 0, 0, 0, 0, 0, 0, 6, 1, 1);
        step(0, 0, 0, 6, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 6, 0, 1, 0, 0, 0, 0);
        // randomized traffic; long enough for the counter to saturate
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 rreg(), rreg(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 rreg(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0));
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_haz.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", exp_haz.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
